nvdla_cvif_rd_ig_skid_pipe: RTL and testbench
=============================================

# nvdla_cvif_rd_ig_skid_pipe

Parametrised valid/ready pipeline stage for the CVIF read ingress path, replacing the fixed 75-bit, two-entry skid stage used in front of each arbiter source. It provides a configurable payload width and an N-entry skid buffer. Ready toward the upstream requester comes directly from a flop, so no combinational path runs from downstream to upstream, and the stage sustains one transfer per cycle. Occupancy and idle status are exported for the arbiter and for clock-gating control.

## Interface
- DW, 75, payload width in bits (legal range 1 to 512)
- DEPTH, 2, number of buffer entries (legal range 2 to 16; need not be a power of two)
- OW, $clog2(DEPTH+1), occupancy width; derived, not overridden
- nvdla_core_clk  in  1  core clock; the only clock
- nvdla_core_rstn  in  1  asynchronous, active-low reset
- in_vld  in  1  upstream request valid
- in_rdy  out  1  upstream ready; driven directly by a flop
- in_pd  in  DW  upstream payload
- out_vld  out  1  request valid toward the arbiter
- out_rdy  in  1  arbiter ready
- out_pd  out  DW  payload toward the arbiter
- occ  out  OW  current number of occupied entries
- idle  out  1  high when occ == 0

## Operation
- The storage is a circular buffer of DEPTH entries, with a write pointer, a read pointer and a count.
- push = in_vld & in_rdy. push writes in_pd at the write pointer, then the write pointer advances.
- pop = out_vld & out_rdy. pop advances the read pointer.
- Both pointers wrap from DEPTH-1 to 0 with an explicit compare. No power-of-two masking is used.
- Next count = count + push - pop. A simultaneous push and pop leaves the count unchanged.
- in_rdy flop is loaded every cycle with (next count < DEPTH). Acceptance therefore can never overflow the buffer.
- out_vld = (count != 0).
- out_pd = entry at the read pointer, read from a flop with no combinational path from in_pd.
- occ = count. idle = (count == 0).
- Payload is held stable while out_vld=1 and out_rdy=0. out_vld never drops without a pop.
- Payload storage flops have no reset. Pointers, count and in_rdy use the async reset.
- in_pd is ignored when push=0. Data is never written when in_rdy=0.

## Timing
- Reset values: in_rdy=1, out_vld=0, occ=0, idle=1. out_pd is undefined until the first push.
- Latency: a push in cycle N gives out_vld=1 with that payload in cycle N+1. There is no same-cycle bypass.
- Throughput is 1 transfer per cycle in steady state when out_rdy=1 continuously (requires DEPTH ≥ 2).
- in_rdy falls in the cycle after the push that makes count == DEPTH with no pop.
- in_rdy rises in the cycle after the first pop from full.
- Full (count == DEPTH) with push and pop in the same cycle cannot occur, because in_rdy=0 at full.
- Empty (count == 0) with pop cannot occur, because out_vld=0 when empty.
- Reset asserted mid-operation clears count and pointers immediately, without waiting for a clock edge. Buffered data is discarded. in_rdy returns to 1 and out_vld to 0 asynchronously.
- Release of nvdla_core_rstn is synchronised upstream of this block. The block does not re-synchronise it.

## Structure
- The shared package nvdla_cvif_pkg holds:
  - the CVIF read request payload width constant (75)
  - a DEPTH legality check used by an elaboration-time assertion (DEPTH ≥ 2)
- One sub-module: nvdla_cvif_ring_ctl. It contains the pointer, count and in_rdy logic, parameterised by DEPTH, and outputs the write enable, write index and read index.
- The payload array is instantiated in the top level.

## Test plan
- Reset then stream: DW=75, DEPTH=2, out_rdy=1, 8 back-to-back pushes with payloads 1 to 8.
  - out_vld high from cycle 1 to cycle 8.
  - out_pd = 1 to 8 in order, in_rdy stays 1 throughout, occ stays at most 1.
- Fill and stall: DEPTH=4, out_rdy=0, in_vld=1 for 6 cycles.
  - Exactly 4 pushes are accepted.
  - in_rdy=0 from the cycle after the 4th push.
  - occ=4 and out_pd holds the 1st payload.
- Drain from full: continue from the fill-and-stall state, then set out_rdy=1 with in_vld=0.
  - Pops return payloads 1 to 4 in order.
  - in_rdy=1 in the cycle after the first pop.
  - idle=1 after the 4th pop.
- Wrap-around: DEPTH=3, random in_vld/out_rdy over 1000 cycles with an incrementing payload.
  - The scoreboard sees in-order, lossless delivery.
  - occ never exceeds 3 and pointers wrap 2→0.
- Mid-operation reset: DEPTH=4 with occ=3, assert nvdla_core_rstn low between clock edges.
  - out_vld=0, occ=0, idle=1 and in_rdy=1 with no clock edge required.
  - The first post-reset push is delivered and stale data is never delivered.
- Simultaneous push and pop: DEPTH=2 at occ=1, in_vld=1 and out_rdy=1 for 1 cycle.
  - occ stays 1 and in_rdy stays 1.
  - The old head is popped and the new payload becomes the head.

Source files
------------

// File: rtl/nvdla_cvif_pkg.sv
// nvdla_cvif_pkg: shared CVIF constants and parameter legality helpers
// Contents:
//   CVIF_RD_REQ_PW - width of a CVIF read request payload
//   depth_ok()     - legality check for skid buffer depth (2..16)
package nvdla_cvif_pkg;
   localparam int CVIF_RD_REQ_PW = 75;
   function automatic bit depth_ok(input int depth);
      return depth >= 2 && depth <= 16;
   endfunction
endpackage

// File: rtl/nvdla_cvif_ring_ctl.sv
// nvdla_cvif_ring_ctl: pointer, count and ready control for an N-entry circular skid buffer
// Ports:
//   nvdla_core_clk, nvdla_core_rstn - clock, async active-low reset
//   in_vld / in_rdy                 - upstream handshake (in_rdy is a flop)
//   out_vld / out_rdy               - downstream handshake
//   occ                             - occupied entry count
//   wr_en, wr_idx, rd_idx           - payload array write enable and indices
module nvdla_cvif_ring_ctl #(
   parameter  int DEPTH = 2,
   localparam int OW    = $clog2(DEPTH + 1),
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          nvdla_core_clk,
   input  logic          nvdla_core_rstn,
   input  logic          in_vld,
   output logic          in_rdy,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [OW-1:0] occ,
   output logic          wr_en,
   output logic [AW-1:0] wr_idx,
   output logic [AW-1:0] rd_idx
);
   logic [OW-1:0] cnt;
   logic [OW-1:0] cnt_nxt;
   logic          pop;
   assign wr_en   = in_vld & in_rdy;
   assign out_vld = cnt != '0;
   assign pop     = out_vld & out_rdy;
   assign cnt_nxt = cnt + OW'(wr_en) - OW'(pop);
   assign occ     = cnt;
   // Ready is registered from the next count so no path runs from out_rdy to in_rdy.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         cnt    <= '0;
         in_rdy <= 1'b1;
         wr_idx <= '0;
         rd_idx <= '0;
      end else begin
         cnt    <= cnt_nxt;
         in_rdy <= cnt_nxt < OW'(DEPTH);
         if (wr_en) wr_idx <= (wr_idx == AW'(DEPTH - 1)) ? '0 : wr_idx + AW'(1);
         if (pop)   rd_idx <= (rd_idx == AW'(DEPTH - 1)) ? '0 : rd_idx + AW'(1);
      end
   end
endmodule

// File: rtl/nvdla_cvif_rd_ig_skid_pipe.sv
// nvdla_cvif_rd_ig_skid_pipe: parametrised valid/ready skid stage for the CVIF read ingress path
// Ports:
//   nvdla_core_clk, nvdla_core_rstn - clock, async active-low reset
//   in_vld / in_rdy / in_pd         - upstream request (in_rdy registered)
//   out_vld / out_rdy / out_pd      - request toward the arbiter (out_pd from storage flops)
//   occ, idle                       - occupancy and empty status
module nvdla_cvif_rd_ig_skid_pipe
   import nvdla_cvif_pkg::*;
#(
   parameter  int DW    = CVIF_RD_REQ_PW,
   parameter  int DEPTH = 2,
   localparam int OW    = $clog2(DEPTH + 1)
) (
   input  logic          nvdla_core_clk,
   input  logic          nvdla_core_rstn,
   input  logic          in_vld,
   output logic          in_rdy,
   input  logic [DW-1:0] in_pd,
   output logic          out_vld,
   input  logic          out_rdy,
   output logic [DW-1:0] out_pd,
   output logic [OW-1:0] occ,
   output logic          idle
);
   localparam int AW = $clog2(DEPTH);
   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("nvdla_cvif_rd_ig_skid_pipe: DEPTH must be in 2..16");
   end
   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic [DW-1:0] mem [DEPTH];
   nvdla_cvif_ring_ctl #(.DEPTH(DEPTH)) u_ctl (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .in_vld          (in_vld),
      .in_rdy          (in_rdy),
      .out_vld         (out_vld),
      .out_rdy         (out_rdy),
      .occ             (occ),
      .wr_en           (wr_en),
      .wr_idx          (wr_idx),
      .rd_idx          (rd_idx)
   );
   // Payload storage is deliberately unreset; validity is tracked by the count alone.
   always_ff @(posedge nvdla_core_clk) begin
      if (wr_en) mem[wr_idx] <= in_pd;
   end
   assign out_pd = mem[rd_idx];
   assign idle   = occ == '0;
endmodule

// File: tb/tb_nvdla_cvif_rd_ig_skid_pipe.sv
// tb_nvdla_cvif_rd_ig_skid_pipe: randomized and directed check of three skid stages (DEPTH 2, 3, 4) against a queue model
module tb_nvdla_cvif_rd_ig_skid_pipe;
   localparam int DW = 75;
   localparam int DP [3] = '{2, 3, 4};
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_vld [3];
   logic          out_rdy [3];
   logic [DW-1:0] in_pd [3];
   logic          in_rdy [3];
   logic          out_vld [3];
   logic          idle [3];
   logic [DW-1:0] out_pd [3];
   logic [1:0]    occ0;
   logic [1:0]    occ1;
   logic [2:0]    occ2;
   int            occ_i [3];
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] q [3][$];
   bit            mrdy [3];
   int            npush [3];
   logic [DW-1:0] last_pop [3];
   always #5 clk = ~clk;
   always_comb begin
      occ_i[0] = int'(occ0);
      occ_i[1] = int'(occ1);
      occ_i[2] = int'(occ2);
   end
   nvdla_cvif_rd_ig_skid_pipe #(.DW(DW), .DEPTH(2)) u0 (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .in_vld(in_vld[0]), .in_rdy(in_rdy[0]),
      .in_pd(in_pd[0]), .out_vld(out_vld[0]), .out_rdy(out_rdy[0]), .out_pd(out_pd[0]),
      .occ(occ0), .idle(idle[0]));
   nvdla_cvif_rd_ig_skid_pipe #(.DW(DW), .DEPTH(3)) u1 (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .in_vld(in_vld[1]), .in_rdy(in_rdy[1]),
      .in_pd(in_pd[1]), .out_vld(out_vld[1]), .out_rdy(out_rdy[1]), .out_pd(out_pd[1]),
      .occ(occ1), .idle(idle[1]));
   nvdla_cvif_rd_ig_skid_pipe #(.DW(DW), .DEPTH(4)) u2 (
      .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .in_vld(in_vld[2]), .in_rdy(in_rdy[2]),
      .in_pd(in_pd[2]), .out_vld(out_vld[2]), .out_rdy(out_rdy[2]), .out_pd(out_pd[2]),
      .occ(occ2), .idle(idle[2]));
   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // Model: a FIFO queue per instance; outputs compared at negedge, then the queue advances
   // using the inputs that the DUT will sample at the next posedge.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            q[i].delete();
            mrdy[i] = 1'b1;
         end
         chk($sformatf("out_vld%0d", i), DW'(out_vld[i]), DW'(q[i].size() != 0));
         chk($sformatf("occ%0d", i), DW'(occ_i[i]), DW'(q[i].size()));
         chk($sformatf("idle%0d", i), DW'(idle[i]), DW'(q[i].size() == 0));
         chk($sformatf("in_rdy%0d", i), DW'(in_rdy[i]), DW'(mrdy[i]));
         if (q[i].size() != 0) chk($sformatf("out_pd%0d", i), out_pd[i], q[i][0]);
         if (rst_n) begin
            if (q[i].size() != 0 && out_rdy[i]) last_pop[i] = q[i].pop_front();
            if (in_vld[i] && mrdy[i]) begin
               q[i].push_back(in_pd[i]);
               npush[i]++;
            end
            mrdy[i] = q[i].size() < DP[i];
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int acc;
      int max_occ;
      logic [DW-1:0] seq;
      for (int i = 0; i < 3; i++) begin
         in_vld[i] = 1'b0; out_rdy[i] = 1'b0; in_pd[i] = '0; npush[i] = 0;
      end
      repeat (2) step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_in_rdy", DW'(in_rdy[i]), DW'(1));
         chk("rst_out_vld", DW'(out_vld[i]), DW'(0));
         chk("rst_idle", DW'(idle[i]), DW'(1));
      end
      // Stream through DEPTH=2
      out_rdy[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         in_vld[0] = 1'b1; in_pd[0] = DW'(k);
         step();
         chk("stream_vld", DW'(out_vld[0]), DW'(1));
         chk("stream_pd", out_pd[0], DW'(k));
         chk("stream_rdy", DW'(in_rdy[0]), DW'(1));
         chk("stream_occ", DW'(occ_i[0]), DW'(1));
      end
      in_vld[0] = 1'b0;
      step();
      chk("stream_idle", DW'(idle[0]), DW'(1));
      // Fill and stall DEPTH=4
      acc = 0;
      for (int k = 1; k <= 6; k++) begin
         in_vld[2] = 1'b1; in_pd[2] = DW'(k);
         if (in_rdy[2]) acc++;
         step();
         if (k >= 4) chk("fill_rdy_low", DW'(in_rdy[2]), DW'(0));
      end
      in_vld[2] = 1'b0;
      chk("fill_accepts", DW'(acc), DW'(4));
      chk("fill_occ", DW'(occ_i[2]), DW'(4));
      chk("fill_head", out_pd[2], DW'(1));
      // Drain from full
      out_rdy[2] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("drain_pd", out_pd[2], DW'(k));
         step();
         if (k == 1) chk("drain_rdy", DW'(in_rdy[2]), DW'(1));
      end
      chk("drain_idle", DW'(idle[2]), DW'(1));
      // Random traffic with wrap on DEPTH=3
      seq = DW'(1000);
      max_occ = 0;
      for (int c = 0; c < 1000; c++) begin
         in_vld[1] = 1'($urandom_range(0, 1));
         out_rdy[1] = ($urandom_range(0, 2) == 0);
         in_pd[1] = seq;
         seq = seq + DW'(1);
         step();
         if (occ_i[1] > max_occ) max_occ = occ_i[1];
      end
      in_vld[1] = 1'b0; out_rdy[1] = 1'b1;
      repeat (4) step();
      chk("rand_max_occ", DW'(max_occ), DW'(3));
      chk("rand_drained", DW'(idle[1]), DW'(1));
      // Mid-operation async reset with DEPTH=4 at occ=3
      out_rdy[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_vld[2] = 1'b1; in_pd[2] = DW'(101 + k);
         step();
      end
      in_vld[2] = 1'b0;
      chk("pre_rst_occ", DW'(occ_i[2]), DW'(3));
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_vld", DW'(out_vld[2]), DW'(0));
      chk("arst_occ", DW'(occ_i[2]), DW'(0));
      chk("arst_idle", DW'(idle[2]), DW'(1));
      chk("arst_in_rdy", DW'(in_rdy[2]), DW'(1));
      step();
      rst_n = 1'b1;
      in_vld[2] = 1'b1; in_pd[2] = DW'(200); out_rdy[2] = 1'b1;
      step();
      in_vld[2] = 1'b0;
      chk("post_rst_vld", DW'(out_vld[2]), DW'(1));
      chk("post_rst_pd", out_pd[2], DW'(200));
      step();
      chk("post_rst_idle", DW'(idle[2]), DW'(1));
      // Simultaneous push and pop on DEPTH=2 at occ=1
      out_rdy[0] = 1'b0; in_vld[0] = 1'b1; in_pd[0] = DW'(11);
      step();
      in_pd[0] = DW'(22); out_rdy[0] = 1'b1;
      step();
      in_vld[0] = 1'b0; out_rdy[0] = 1'b0;
      chk("pp_occ", DW'(occ_i[0]), DW'(1));
      chk("pp_rdy", DW'(in_rdy[0]), DW'(1));
      chk("pp_head", out_pd[0], DW'(22));
      step();
      chk("pp_popped", last_pop[0], DW'(11));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
